univ_shift_reg_burst: RTL and testbench



---
 rtl/univ_shift_reg_burst.sv | 190 +++++++++++++++++++
 tb/tb_univ_shift_reg_burst.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_burst.sv
// univ_shift_reg_burst
//   Parametrised universal shift register with hold, logical shift right/left,
//   parallel load, rotate right/left and arithmetic shift right, plus a
//   counted burst engine that performs up to 2^CNT_W-1 shifts from a single
//   start request.
//
// Ports
//   clk    : system clock, all state changes on the rising edge
//   rst    : synchronous active-high reset (highest priority)
//   en     : operation enable; low holds q and stalls a running burst
//   mode   : operation select (000 hold, 001 shr, 010 shl, 011 load,
//            100 rotr, 101 rotl, 110 asr, 111 hold)
//   sin_l  : serial input entering at the MSB on right shifts
//   sin_r  : serial input entering at the LSB on left shifts
//   pdata  : parallel load data
//   start  : burst request, honoured only while idle
//   shamt  : burst length, captured together with start
//   q      : register contents
//   sout_l : q MSB
//   sout_r : q LSB
//   busy   : burst in progress
//   done   : single-cycle burst completion pulse
module univ_shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_lat_q, mode_lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_accept_s;

  // Only shifting/rotating modes can be repeated as a burst; hold, load and
  // the reserved code ignore start.
  function automatic logic is_burst_mode(input logic [2:0] m);
    logic r;
    case (m)
      3'b001, 3'b010, 3'b100, 3'b101, 3'b110: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // One application of an operation to the current register value.
  function automatic logic [WIDTH-1:0] shift_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] pd
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b001:  r = {sl, cur[WIDTH-1:1]};
      3'b010:  r = {cur[WIDTH-2:0], sr};
      3'b011:  r = pd;
      3'b100:  r = {cur[0], cur[WIDTH-1:1]};
      3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  assign start_accept_s = (state_q == ST_IDLE) && start && en && is_burst_mode(mode);

  // State register and all datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      q_q        <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      mode_lat_q <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      mode_lat_q <= mode_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: a burst of two or more shifts enters BURST; the edge
  // that performs the last shift returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_accept_s && (shamt > CNT_W'(1))) begin
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (en && (cnt_q <= CNT_W'(1))) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BURST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: next register value, remaining count, latched
  // mode and the registered busy/done flags.
  always_comb begin
    q_d        = q_q;
    cnt_d      = cnt_q;
    mode_lat_d = mode_lat_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_accept_s) begin
          mode_lat_d = mode;
          if (shamt == {CNT_W{1'b0}}) begin
            // Zero-length burst: nothing moves, completion is reported anyway.
            cnt_d  = {CNT_W{1'b0}};
            done_d = 1'b1;
          end else begin
            // The start edge already performs the first shift.
            q_d   = shift_op(mode, q_q, sin_l, sin_r, pdata);
            cnt_d = shamt - CNT_W'(1);
            if (shamt == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              busy_d = 1'b1;
            end
          end
        end else if (en) begin
          q_d = shift_op(mode, q_q, sin_l, sin_r, pdata);
        end else begin
          q_d = q_q;
        end
      end
      ST_BURST: begin
        if (en) begin
          // Live mode/pdata/start are ignored; serial inputs stay live.
          q_d   = shift_op(mode_lat_q, q_q, sin_l, sin_r, pdata);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
module tb_univ_shift_reg_burst;

  logic       clk = 1'b0;
  logic       rst, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] pdata;
  logic [3:0] shamt;
  logic [7:0] q;
  logic       sout_l, sout_r, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_q = 0;
  int m_busy = 0;
  int m_done = 0;
  int m_left = 0;
  int m_mode = 0;

  univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdata(pdata), .start(start), .shamt(shamt), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Arithmetic description of each operation on an 8-bit value.
  function automatic int op(input int m, input int x, input int sl, input int sr, input int pd);
    case (m)
      1: return x / 2 + sl * 128;
      2: return (x * 2) % 256 + sr;
      3: return pd;
      4: return x / 2 + (x % 2) * 128;
      5: return (x * 2) % 256 + x / 128;
      6: return x / 2 + (x / 128) * 128;
      default: return x;
    endcase
  endfunction

  function automatic bit shifting(input int m);
    return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    if (rst) begin
      m_q = 0; m_busy = 0; m_done = 0; m_left = 0; m_mode = 0;
    end else begin
      m_done = 0;
      if (m_busy != 0) begin
        if (en) begin
          m_q = op(m_mode, m_q, int'(sin_l), int'(sin_r), int'(pdata));
          m_left = m_left - 1;
          if (m_left == 0) begin m_busy = 0; m_done = 1; end
        end
      end else if (start && en && shifting(int'(mode))) begin
        m_mode = int'(mode);
        if (shamt == 4'd0) m_done = 1;
        else begin
          m_q = op(m_mode, m_q, int'(sin_l), int'(sin_r), int'(pdata));
          m_left = int'(shamt) - 1;
          if (m_left == 0) m_done = 1; else m_busy = 1;
        end
      end else if (en) begin
        m_q = op(int'(mode), m_q, int'(sin_l), int'(sin_r), int'(pdata));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    rst = 1'b0; en = 1'b1; start = 1'b0; mode = 3'b011; pdata = v;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); start = 1'($urandom); mode = 3'($urandom);
      pdata = 8'($urandom); shamt = 4'($urandom);
      sin_l = 1'($urandom); sin_r = 1'($urandom);
      tick();
    end
    n_checks++;
    if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    rst = 1'b0; en = 1'b0; start = 1'b0;
  endtask

  task automatic test_single_step();
    do_load(8'hA5);
    n_checks++;
    if (q !== 8'hA5) $display("FAIL step_load: got %h want a5", q); else n_pass++;
    en = 1'b1; mode = 3'b001; sin_l = 1'b1; tick();
    n_checks++;
    if (q !== 8'hD2) $display("FAIL step_shr: got %h want d2", q); else n_pass++;
    n_checks++;
    if (sout_l !== 1'b1 || sout_r !== 1'b0)
      $display("FAIL step_sout: got %b%b want 10", sout_l, sout_r);
    else n_pass++;
    mode = 3'b010; sin_r = 1'b0; tick();
    n_checks++;
    if (q !== 8'hA4) $display("FAIL step_shl: got %h want a4", q); else n_pass++;
    mode = 3'b111; tick();
    n_checks++;
    if (q !== 8'hA4) $display("FAIL step_reserved: got %h want a4", q); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_burst_rotl();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    do_load(8'h81);
    en = 1'b1; start = 1'b1; mode = 3'b101; shamt = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'b0; mode = 3'($urandom); pdata = 8'($urandom);
      n_checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2))
        $display("FAIL burst_rotl[%0d]: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, exp_q[i], (i < 2), (i == 2));
      else n_pass++;
    end
    en = 1'b0; tick();
    n_checks++;
    if (done !== 1'b0 || q !== 8'h0C) $display("FAIL rotl_after: got q=%h done=%b want 0c 0", q, done);
    else n_pass++;
  endtask

  task automatic test_burst_asr_stall();
    do_load(8'h90);
    en = 1'b1; start = 1'b1; mode = 3'b110; shamt = 4'd2;
    tick();
    start = 1'b0;
    n_checks++;
    if (q !== 8'hC8 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL asr_k: got q=%h busy=%b done=%b want c8 1 0", q, busy, done);
    else n_pass++;
    en = 1'b0; tick();
    n_checks++;
    if (q !== 8'hC8 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL asr_stall: got q=%h busy=%b done=%b want c8 1 0", q, busy, done);
    else n_pass++;
    en = 1'b1; tick();
    n_checks++;
    if (q !== 8'hE4 || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL asr_final: got q=%h busy=%b done=%b want e4 0 1", q, busy, done);
    else n_pass++;
    en = 1'b0; tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL asr_pulse: got done=%b want 0", done); else n_pass++;
  endtask

  task automatic test_start_in_burst();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h5B; exp_q[1] = 8'h2D; exp_q[2] = 8'h16; exp_q[3] = 8'h0B;
    do_load(8'hB7);
    en = 1'b1; start = 1'b1; mode = 3'b001; shamt = 4'd4; sin_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mode = 3'b100; shamt = 4'd7;
      start = (i < 2);
      n_checks++;
      if (q !== exp_q[i] || busy !== (i < 3) || done !== (i == 3))
        $display("FAIL start_in_burst[%0d]: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, exp_q[i], (i < 3), (i == 3));
      else n_pass++;
    end
    en = 1'b0; tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h0B)
      $display("FAIL start_in_burst_end: got q=%h busy=%b done=%b want 0b 0 0", q, busy, done);
    else n_pass++;
  endtask

  task automatic test_shamt_zero();
    en = 1'b1; start = 1'b1; mode = 3'b010; shamt = 4'd0; sin_r = 1'b1;
    tick();
    n_checks++;
    if (q !== 8'h0B || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL shamt0: got q=%h busy=%b done=%b want 0b 0 1", q, busy, done);
    else n_pass++;
    start = 1'b0; en = 1'b0; tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL shamt0_after: got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_load(8'hFF);
    en = 1'b1; start = 1'b1; mode = 3'b001; shamt = 4'd10; sin_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL mid_busy[%0d]: got %b want 1", i, busy); else n_pass++;
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset: got q=%h busy=%b done=%b want 00 0 0", q, busy, done);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL mid_nodone[%0d]: got busy=%b done=%b want 0 0", i, busy, done);
      else n_pass++;
    end
    en = 1'b1; start = 1'b1; mode = 3'b010; shamt = 4'd1; sin_r = 1'b1;
    tick();
    start = 1'b0; en = 1'b0;
    n_checks++;
    if (q !== 8'h01 || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL post_reset_burst: got q=%h busy=%b done=%b want 01 0 1", q, busy, done);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      en    = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 2) == 0);
      mode  = 3'($urandom);
      pdata = 8'($urandom);
      shamt = 4'($urandom_range(0, 6));
      sin_l = 1'($urandom);
      sin_r = 1'($urandom);
      tick();
      n_checks++;
      if (int'(q) !== m_q || int'(busy) !== m_busy || int'(done) !== m_done ||
          int'(sout_l) !== m_q / 128 || int'(sout_r) !== m_q % 2)
        $display("FAIL random[%0d]: got q=%h busy=%b done=%b sl=%b sr=%b want q=%h busy=%0d done=%0d",
                 i, q, busy, done, sout_l, sout_r, m_q[7:0], m_busy, m_done);
      else n_pass++;
    end
    rst = 1'b0; start = 1'b0; en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; mode = 3'b000;
    pdata = 8'h00; shamt = 4'd0; sin_l = 1'b0; sin_r = 1'b0;
    test_reset();
    test_single_step();
    test_burst_rotl();
    test_burst_asr_stall();
    test_start_in_burst();
    test_shamt_zero();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
